// File: rtl/aor3000_if_pkg.sv
// Shared types for the instruction-fetch stage.
// S_HALT exists only when AOR3000_IF_BUS_ERROR_EN is defined.
package aor3000_if_pkg;

    localparam int DEF_FIFO_DEPTH      = 2;
    localparam int DEF_MAX_OUTSTANDING = 2;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
`ifdef AOR3000_IF_BUS_ERROR_EN
        , S_HALT
`endif
    } if_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bus_err;
    } if_entry_t;

endpackage

// File: rtl/aor3000_if_fifo.sv
// Synchronous FIFO with clear and registered head (no fall-through).
// Depth need not be a power of two; pointers wrap explicitly.
module aor3000_if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr, wptr;
    logic             full, do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push at full is legal only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= inc(wptr);
            if (do_pop)  rptr <= inc(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr] <= din;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/aor3000_if_stage.sv
// Instruction-fetch stage: in-order reads at the PC, in-flight PC tracking, decode queue, flush drop.
// Bus-error reporting (i_mem_err, o_ID_bus_err, S_HALT) is built when AOR3000_IF_BUS_ERROR_EN is defined.
module aor3000_if_stage
    import aor3000_if_pkg::*;
#(
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_PC_counter,
    input  logic        i_flush,
    output logic        o_PC_update,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
`ifdef AOR3000_IF_BUS_ERROR_EN
    input  logic        i_mem_err,
    output logic        o_ID_bus_err,
`endif
    output logic        o_ID_valid,
    output logic [31:0] o_ID_instr,
    output logic [31:0] o_ID_pc,
    input  logic        i_ID_ready
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(FIFO_DEPTH + 1);

    if_state_t     state, state_nxt;
    logic [OW-1:0] outstanding, drop_count, drop_nxt;
    logic [QW-1:0] q_count;
    logic          q_empty, q_push, q_pop, live_rsp, rsp_err, unused_trk_empty;
    logic [31:0]   trk_pc;
    if_entry_t     q_in, q_head;
    int            drop_sum;

`ifdef AOR3000_IF_BUS_ERROR_EN
    assign rsp_err = i_mem_err;
`else
    logic unused_bus_err;
    assign rsp_err        = 1'b0;
    assign unused_bus_err = q_head.bus_err;
`endif

    assign live_rsp   = i_mem_rvalid && (drop_count == '0);
    assign q_push     = live_rsp && !i_flush;
    assign q_pop      = o_ID_valid && i_ID_ready;
    assign q_in       = '{pc: trk_pc, instr: i_mem_rdata, bus_err: rsp_err};
    assign o_mem_addr = i_PC_counter;

    // The tracker count doubles as the live outstanding counter.
    aor3000_if_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_trk (
        .clk   (clk),
        .rst   (rst),
        .clear (i_flush),
        .push  (o_PC_update),
        .din   (i_PC_counter),
        .pop   (q_push),
        .dout  (trk_pc),
        .empty (unused_trk_empty),
        .count (outstanding)
    );

    aor3000_if_fifo #(.WIDTH($bits(if_entry_t)), .DEPTH(FIFO_DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (i_flush),
        .push  (q_push),
        .din   (q_in),
        .pop   (q_pop),
        .dout  (q_head),
        .empty (q_empty),
        .count (q_count)
    );

    // Words still owed by memory at a flush become drops; a same-cycle live word is already gone.
    always_comb begin
        drop_sum = int'(drop_count) - ((i_mem_rvalid && drop_count != '0) ? 1 : 0);
        if (i_flush)
            drop_sum = drop_sum + int'(outstanding) - (live_rsp ? 1 : 0);
        drop_nxt = OW'(drop_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BOOT;
            drop_count <= '0;
        end else begin
            state      <= state_nxt;
            drop_count <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_BOOT)
            state_nxt = S_RUN;
        else if (i_flush)
            state_nxt = (drop_nxt != '0) ? S_FLUSH : S_RUN;
        else if (state == S_FLUSH && drop_nxt == '0)
            state_nxt = S_RUN;
`ifdef AOR3000_IF_BUS_ERROR_EN
        else if (q_push && rsp_err)
            state_nxt = S_HALT;
`endif
    end

    // Credit check: every issued read owns a queue slot before it is sent.
    always_comb begin
        o_mem_req   = (state == S_RUN) && !i_flush
                   && (int'(outstanding) < MAX_OUTSTANDING)
                   && (int'(outstanding) + int'(q_count) < FIFO_DEPTH);
        o_PC_update = o_mem_req && i_mem_ack;
    end

    assign o_ID_valid = !q_empty;
    assign o_ID_instr = o_ID_valid ? q_head.instr : '0;
    assign o_ID_pc    = o_ID_valid ? q_head.pc    : '0;
`ifdef AOR3000_IF_BUS_ERROR_EN
    assign o_ID_bus_err = o_ID_valid && q_head.bus_err;
`endif

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        !(i_mem_rvalid && outstanding == '0 && drop_count == '0));

endmodule

// File: tb/tb_aor3000_if_stage.sv
// Randomized bench for aor3000_if_stage against a request/epoch reference model.
// Bus-error scenario is compiled when AOR3000_IF_BUS_ERROR_EN is defined.
module tb_aor3000_if_stage;

    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_PC_counter;
    logic        i_flush, o_PC_update, o_mem_req, i_mem_ack, i_mem_rvalid;
    logic [31:0] o_mem_addr, i_mem_rdata, o_ID_instr, o_ID_pc;
    logic        o_ID_valid, i_ID_ready;
`ifdef AOR3000_IF_BUS_ERROR_EN
    logic        i_mem_err, o_ID_bus_err;
`endif

    always #5 clk = ~clk;

    aor3000_if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .i_PC_counter (i_PC_counter),
        .i_flush      (i_flush),
        .o_PC_update  (o_PC_update),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
`ifdef AOR3000_IF_BUS_ERROR_EN
        .i_mem_err    (i_mem_err),
        .o_ID_bus_err (o_ID_bus_err),
`endif
        .o_ID_valid   (o_ID_valid),
        .o_ID_instr   (o_ID_instr),
        .o_ID_pc      (o_ID_pc),
        .i_ID_ready   (i_ID_ready)
    );

    // Model: every accepted read is tagged with the redirect epoch it was issued in;
    // only words of the current epoch that arrive outside a flush reach decode.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          ep;
    } pend_t;

    pend_t       pend[$];
    logic [64:0] expq[$];
    logic [31:0] seen_pc[$];
    logic [31:0] seen_instr[$];
    logic        seen_err[$];
    logic [31:0] pc_model;
    int          epoch = 0;
    bit          boot, halt, err_en;
    logic [31:0] err_pc;
    logic        last_req;
    int          pupd_cnt;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic model_clear();
        pend.delete();
        expq.delete();
        halt  = 0;
        epoch = epoch + 1;
    endtask

    // One clock: drive at edge+1, sample at the falling edge, advance the model, return at edge+1.
    task automatic step(input int p_ack, input int p_rv, input int p_rdy, input bit fl,
                        input logic [31:0] redirect);
        bit          ack, rv, rdy, e, exp_req;
        int          dead;
        pend_t       h;
        logic [64:0] act;
        ack = ($urandom_range(99) < p_ack);
        rv  = (pend.size() != 0) && ($urandom_range(99) < p_rv);
        rdy = ($urandom_range(99) < p_rdy);
        e   = rv && err_en && (pend[0].pc == err_pc);
        i_PC_counter = pc_model;
        i_flush      = fl;
        i_mem_ack    = ack;
        i_mem_rvalid = rv;
        i_mem_rdata  = rv ? pend[0].data : $urandom;
        i_ID_ready   = rdy;
`ifdef AOR3000_IF_BUS_ERROR_EN
        i_mem_err    = e;
`endif
        @(negedge clk);
        dead = 0;
        foreach (pend[i]) if (pend[i].ep != epoch) dead++;
        exp_req = !boot && !halt && dead == 0 && !fl && pend.size() < MAXO
                  && pend.size() + expq.size() < DEPTH;
`ifdef AOR3000_IF_BUS_ERROR_EN
        act = {o_ID_pc, o_ID_instr, o_ID_bus_err};
`else
        act = {o_ID_pc, o_ID_instr, 1'b0};
`endif
        last_req = o_mem_req;
        if (o_PC_update === 1'b1) pupd_cnt++;
        n_checks++;
        if (o_mem_req !== exp_req) begin
            n_fail++; $display("FAIL mem_req: got %b expected %b (pc %h)", o_mem_req, exp_req, pc_model);
        end
        n_checks++;
        if (o_mem_addr !== pc_model) begin
            n_fail++; $display("FAIL mem_addr: got %h expected %h", o_mem_addr, pc_model);
        end
        n_checks++;
        if (o_PC_update !== (exp_req && ack)) begin
            n_fail++; $display("FAIL pc_update: got %b expected %b", o_PC_update, exp_req && ack);
        end
        n_checks++;
        if (o_ID_valid !== (expq.size() != 0)) begin
            n_fail++; $display("FAIL id_valid: got %b expected %b", o_ID_valid, expq.size() != 0);
        end
        if (expq.size() != 0) begin
            n_checks++;
            if (act !== expq[0]) begin
                n_fail++; $display("FAIL id_head: got %h expected %h", act, expq[0]);
            end
            if (rdy && !fl) begin
                seen_pc.push_back(o_ID_pc);
                seen_instr.push_back(o_ID_instr);
                seen_err.push_back(act[0]);
                void'(expq.pop_front());
            end
        end
        if (rv) begin
            h = pend.pop_front();
            if (h.ep == epoch && !fl) begin
                expq.push_back({h.pc, h.data, e});
                if (e) halt = 1;
            end
        end
        if (fl) begin
            expq.delete();
            epoch    = epoch + 1;
            halt     = 0;
            pc_model = redirect;
        end else if (exp_req && ack) begin
            h.pc = pc_model; h.data = $urandom; h.ep = epoch;
            pend.push_back(h);
            pc_model = pc_model + 32'd4;
        end
        boot = 0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((pend.size() != 0 || expq.size() != 0) && k < 40) begin
            step(0, 100, 100, 0, 32'h0);
            k++;
        end
        n_checks++;
        if (pend.size() != 0 || expq.size() != 0) begin
            n_fail++; $display("FAIL drain: %0d pending %0d queued, expected 0", pend.size(), expq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_flush = 0; i_mem_ack = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        i_ID_ready = 0; i_PC_counter = 32'hBFC0_0000;
`ifdef AOR3000_IF_BUS_ERROR_EN
        i_mem_err = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", o_mem_req); end
        n_checks++;
        if (o_PC_update !== 1'b0) begin n_fail++; $display("FAIL reset_pcupd: got %b expected 0", o_PC_update); end
        n_checks++;
        if (o_ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_ID_valid); end
        n_checks++;
        if ({o_ID_pc, o_ID_instr} !== 64'h0) begin
            n_fail++; $display("FAIL reset_head: got %h expected 0", {o_ID_pc, o_ID_instr});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        pc_model = 32'hBFC0_0000;
        boot = 1;
    endtask

    task automatic test_straight_line();
        seen_pc.delete();
        pupd_cnt = 0;
        repeat (30) step(100, 100, 100, 0, 32'h0);
        n_checks++;
        if (pupd_cnt != int'((pc_model - 32'hBFC0_0000) >> 2)) begin
            n_fail++; $display("FAIL straight_pupd: got %0d pulses expected %0d", pupd_cnt, (pc_model - 32'hBFC0_0000) >> 2);
        end
        n_checks++;
        if (seen_pc.size() < 8) begin
            n_fail++; $display("FAIL straight_count: got %0d words expected >= 8", seen_pc.size());
        end
        for (int i = 0; i < seen_pc.size(); i++) begin
            n_checks++;
            if (seen_pc[i] !== 32'hBFC0_0000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL straight_pc[%0d]: got %h expected %h", i, seen_pc[i], 32'hBFC0_0000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        step(0, 100, 100, 1, 32'hBFC0_0000);
        seen_pc.delete();
        nreq = 0;
        repeat (10) begin
            step(100, 100, 0, 0, 32'h0);
            nreq += int'(last_req);
        end
        n_checks++;
        if (nreq > 2) begin n_fail++; $display("FAIL bp_req_count: got %0d expected <= 2", nreq); end
        n_checks++;
        if (last_req !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b expected 0", last_req); end
        n_checks++;
        if (o_ID_valid !== 1'b1 || o_ID_pc !== 32'hBFC0_0000) begin
            n_fail++; $display("FAIL bp_head: got valid %b pc %h expected 1 bfc00000", o_ID_valid, o_ID_pc);
        end
        repeat (15) step(100, 100, 100, 0, 32'h0);
        for (int i = 0; i < seen_pc.size(); i++) begin
            n_checks++;
            if (seen_pc[i] !== 32'hBFC0_0000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, seen_pc[i], 32'hBFC0_0000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_flush();
        int nreq;
        drain();
        step(100, 0, 100, 0, 32'h0);
        nreq = int'(last_req);
        step(100, 0, 100, 0, 32'h0);
        nreq += int'(last_req);
        n_checks++;
        if (nreq != 2) begin n_fail++; $display("FAIL flush_setup: got %0d requests expected 2", nreq); end
        if (pend.size() == 2) begin
            pend[0].data = 32'hDEAD_0001;
            pend[1].data = 32'hDEAD_0002;
        end
        step(0, 0, 100, 1, 32'h8000_0180);
        seen_pc.delete();
        seen_instr.delete();
        nreq = 0;
        repeat (2) begin
            step(100, 100, 100, 0, 32'h0);
            nreq += int'(last_req);
        end
        n_checks++;
        if (nreq != 0) begin n_fail++; $display("FAIL flush_no_req: got %0d requests expected 0", nreq); end
        repeat (8) step(100, 100, 100, 0, 32'h0);
        n_checks++;
        if (seen_pc.size() == 0 || seen_pc[0] !== 32'h8000_0180) begin
            n_fail++; $display("FAIL flush_first_pc: got %h expected 80000180", seen_pc.size() ? seen_pc[0] : 32'hx);
        end
        foreach (seen_instr[i]) begin
            n_checks++;
            if (seen_instr[i] === 32'hDEAD_0001 || seen_instr[i] === 32'hDEAD_0002) begin
                n_fail++; $display("FAIL flush_dropped: got %h expected a post-flush word", seen_instr[i]);
            end
        end
    endtask

    task automatic test_flush_rvalid();
        drain();
        step(100, 0, 100, 0, 32'h0);
        n_checks++;
        if (last_req !== 1'b1) begin n_fail++; $display("FAIL flrv_setup: got %b expected 1", last_req); end
        step(0, 100, 100, 1, 32'h0000_2000);
        seen_pc.delete();
        step(100, 0, 100, 0, 32'h0);
        n_checks++;
        if (last_req !== 1'b1) begin n_fail++; $display("FAIL flrv_resume: got %b expected 1", last_req); end
        repeat (6) step(100, 100, 100, 0, 32'h0);
        n_checks++;
        if (seen_pc.size() == 0 || seen_pc[0] !== 32'h0000_2000) begin
            n_fail++; $display("FAIL flrv_first_pc: got %h expected 00002000", seen_pc.size() ? seen_pc[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        repeat (600)
            step($urandom_range(100), $urandom_range(100), $urandom_range(100),
                 $urandom_range(99) < 3, $urandom & 32'hFFFF_FFFC);
        drain();
    endtask

`ifdef AOR3000_IF_BUS_ERROR_EN
    task automatic test_bus_err();
        int nreq, idx;
        drain();
        step(0, 0, 100, 1, 32'hBFC0_0000);
        err_en = 1; err_pc = 32'hBFC0_0008;
        seen_pc.delete(); seen_err.delete();
        repeat (10) step(100, 100, 100, 0, 32'h0);
        nreq = 0;
        repeat (4) begin
            step(100, 100, 100, 0, 32'h0);
            nreq += int'(last_req);
        end
        err_en = 0;
        n_checks++;
        if (nreq != 0) begin n_fail++; $display("FAIL halt_no_req: got %0d requests expected 0", nreq); end
        idx = -1;
        foreach (seen_pc[i]) if (seen_pc[i] === 32'hBFC0_0008) idx = i;
        n_checks++;
        if (idx < 0 || seen_err[idx] !== 1'b1) begin
            n_fail++; $display("FAIL bus_err_flag: got idx %0d err %b expected err 1", idx, idx < 0 ? 1'bx : seen_err[idx]);
        end
        step(0, 100, 100, 1, 32'h0000_3000);
        step(100, 0, 100, 0, 32'h0);
        n_checks++;
        if (last_req !== 1'b1) begin n_fail++; $display("FAIL halt_resume: got %b expected 1", last_req); end
    endtask
`endif

    task automatic test_reset_mid();
        repeat (3) step(100, 0, 0, 0, 32'h0);
        step(0, 100, 0, 0, 32'h0);
        n_checks++;
        if (o_ID_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got %b expected 1", o_ID_valid); end
        i_mem_ack = 1'b1;
        rst = 1'b1;
        #2;
        n_checks++;
        if ({o_mem_req, o_PC_update, o_ID_valid} !== 3'b000) begin
            n_fail++; $display("FAIL rmid_ctrl: got %b expected 000", {o_mem_req, o_PC_update, o_ID_valid});
        end
        n_checks++;
        if ({o_ID_pc, o_ID_instr} !== 64'h0) begin
            n_fail++; $display("FAIL rmid_head: got %h expected 0", {o_ID_pc, o_ID_instr});
        end
        model_clear();
        pc_model = 32'hBFC0_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        boot = 1;
        step(100, 0, 100, 0, 32'h0);
        n_checks++;
        if (last_req !== 1'b0) begin n_fail++; $display("FAIL rmid_boot: got %b expected 0", last_req); end
        step(100, 0, 100, 0, 32'h0);
        n_checks++;
        if (last_req !== 1'b1) begin n_fail++; $display("FAIL rmid_first_req: got %b expected 1", last_req); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        err_en = 0; err_pc = 32'h0; halt = 0; boot = 0; pupd_cnt = 0;
        test_reset();
        test_straight_line();
        test_backpressure();
        test_flush();
        test_flush_rvalid();
        test_random();
`ifdef AOR3000_IF_BUS_ERROR_EN
        test_bus_err();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
